// File: rtl/accel_pkg.sv
// Shared accelerator types: memory controller request/response, bank geometry
// and the tag carried by mem_arbiter for outstanding reads.
package accel_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 16;
  localparam int BRAM_BANKS      = 24;
  localparam int BANK_W          = 5;
  localparam int MEM_ARB_MAX_REQ = 8;
  localparam int ARB_ID_W        = $clog2(MEM_ARB_MAX_REQ);

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [BANK_W-1:0]     bank_sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } mem_resp_t;

  typedef struct packed {
    logic                valid;
    logic                err;
    logic [ARB_ID_W-1:0] id;
  } arb_tag_t;

  // True when bank exists and is powered; scanning avoids indexing past BRAM_BANKS.
  function automatic logic bank_powered(input logic [BANK_W-1:0]     bank,
                                        input logic [BRAM_BANKS-1:0] pwr);
    logic ok;
    ok = 1'b0;
    for (int b = 0; b < BRAM_BANKS; b++) begin
      if (int'(bank) == b) ok = pwr[b];
    end
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin pick with its rotating priority pointer; the search starts
// at rr_ptr and the pointer moves past the winner on every accepted grant.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     valid,
  input  logic             accept,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] winner,
  output logic             any_valid
);

  logic [PTR_W-1:0] rr_ptr;

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_v;
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_v = PTR_W'(idx);
      if (!any_valid && valid[idx_v]) begin
        any_valid     = 1'b1;
        grant[idx_v]  = 1'b1;
        winner        = idx_v;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && any_valid) begin
      rr_ptr <= (winner == PTR_W'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of the memory_controller port with read-tag routing.
// Define MEM_ARB_PWR_CHECK_EN to block requests to missing/unpowered banks.
module mem_arbiter
  import accel_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  mem_req_t              req_in [N_REQ],
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output mem_req_t              mem_req,
  input  mem_resp_t             mem_resp,
  input  logic [BRAM_BANKS-1:0] bank_power_en,
  output logic                  busy
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] win_idx;
  logic             acc;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .accept    (acc),
    .grant     (grant),
    .winner    (win_idx),
    .any_valid (acc)
  );

  assign req_ready = grant & {N_REQ{~rst}};

  mem_req_t sel_req;
  mem_req_t mem_req_nxt;
  arb_tag_t iss_tag_nxt;
  arb_tag_t iss_tag_p0;
  arb_tag_t tag_p1 [RD_LAT];
  arb_tag_t head;
  logic     fwd_ok;
  logic     is_wr;
  logic     is_rd;
  logic     busy_nxt;
  logic     resp_hit;

`ifdef MEM_ARB_PWR_CHECK_EN
  assign fwd_ok = bank_powered(sel_req.bank_sel, bank_power_en);
`else
  logic unused_pwr;
  assign unused_pwr = ^bank_power_en;
  assign fwd_ok     = 1'b1;
`endif

  // we+re together counts as a write; neither set is consumed as a no-op.
  always_comb begin
    sel_req        = req_in[win_idx];
    is_wr          = sel_req.we;
    is_rd          = sel_req.re & ~sel_req.we;
    mem_req_nxt    = mem_req;
    mem_req_nxt.we = 1'b0;
    mem_req_nxt.re = 1'b0;
    iss_tag_nxt    = '0;
    if (acc) begin
      mem_req_nxt.bank_sel = sel_req.bank_sel;
      mem_req_nxt.addr     = sel_req.addr;
      mem_req_nxt.data     = sel_req.data;
      mem_req_nxt.we       = is_wr & fwd_ok;
      mem_req_nxt.re       = is_rd & fwd_ok;
      iss_tag_nxt.valid    = is_rd;
      iss_tag_nxt.err      = ~fwd_ok;
      iss_tag_nxt.id       = ARB_ID_W'(win_idx);
    end
  end

  always_comb begin
    busy_nxt = mem_req_nxt.we | mem_req_nxt.re | iss_tag_nxt.valid | iss_tag_p0.valid;
    for (int k = 0; k < RD_LAT - 1; k++) begin
      busy_nxt = busy_nxt | tag_p1[k].valid;
    end
  end

  // Stage p0: issue register (mem_req + tag of the op it carries).
  // Stage p1: tag delay line matching the controller read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= '0;
      iss_tag_p0 <= '0;
      busy       <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) tag_p1[k] <= '0;
    end else begin
      mem_req    <= mem_req_nxt;
      iss_tag_p0 <= iss_tag_nxt;
      busy       <= busy_nxt;
      tag_p1[0]  <= iss_tag_p0;
      for (int k = 1; k < RD_LAT; k++) tag_p1[k] <= tag_p1[k-1];
    end
  end

  // Blocked reads answer on their own; good reads wait for the controller strobe.
  assign head = tag_p1[RD_LAT-1];

  always_comb begin
    resp_hit   = head.valid & (head.err | mem_resp.valid);
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (resp_hit && (head.id == ARB_ID_W'(i))) resp_valid[i] = 1'b1;
    end
    resp_data = (resp_hit && !head.err) ? mem_resp.data : '0;
  end

`ifdef MEM_ARB_PWR_CHECK_EN
  assign resp_err = resp_hit & head.err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-indexed
// scoreboard and a pipelined memory_controller model.
module tb_mem_arbiter;
  import accel_pkg::*;

  localparam int N_REQ  = 4;
  localparam int RD_LAT = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  mem_req_t              req_in [N_REQ];
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  mem_req_t              mem_req;
  mem_resp_t             mem_resp;
  logic [BRAM_BANKS-1:0] bank_power_en;
  logic                  busy;

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N_REQ), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_in        (req_in),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .mem_req       (mem_req),
    .mem_resp      (mem_resp),
    .bank_power_en (bank_power_en),
    .busy          (busy)
  );

  function automatic int mkey(input logic [BANK_W-1:0] b, input logic [ADDR_WIDTH-1:0] a);
    return int'(b) * 64 + int'(a[5:0]);
  endfunction

  // Pipelined controller: read data appears RD_LAT cycles after re is presented.
  logic [DATA_WIDTH-1:0] ctl_mem [2048] = '{default: '0};
  logic [RD_LAT-1:0]     cv = '0;
  logic [DATA_WIDTH-1:0] cd [RD_LAT];

  always @(posedge clk) begin
    for (int k = RD_LAT - 1; k > 0; k--) begin
      cv[k] <= cv[k-1];
      cd[k] <= cd[k-1];
    end
    cv[0] <= mem_req.re;
    cd[0] <= ctl_mem[mkey(mem_req.bank_sel, mem_req.addr)];
    if (mem_req.we) ctl_mem[mkey(mem_req.bank_sel, mem_req.addr)] <= mem_req.data;
  end

  assign mem_resp.valid = cv[RD_LAT-1];
  assign mem_resp.data  = cd[RD_LAT-1];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ptr = 0;
  int last_win = -1;

  logic [DATA_WIDTH-1:0] refmem [int];
  int                    rsp_id [int];
  logic [DATA_WIDTH-1:0] rsp_dat [int];
  logic                  rsp_er [int];
  mem_req_t              op_map [int];
  bit                    busy_map [int];
  logic [N_REQ-1:0]      obs_rv [int];
  logic [DATA_WIDTH-1:0] obs_rd [int];
  logic                  obs_err [int];
  logic                  obs_we [int];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic observe();
    logic [N_REQ-1:0] eg;
    logic [N_REQ-1:0] ev;
    mem_req_t         p;
    mem_req_t         op;
    int               win;
    int               key;
    int               b;
    bit               ok;
    bit               wr;
    bit               rd;
    obs_rv[cyc]  = resp_valid;
    obs_rd[cyc]  = resp_data;
    obs_err[cyc] = resp_err;
    obs_we[cyc]  = mem_req.we;
    last_win     = -1;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      rsp_id.delete(); rsp_dat.delete(); rsp_er.delete();
      op_map.delete(); busy_map.delete();
      ptr = 0;
      return;
    end
    win = -1;
    eg  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win < 0 && req_valid[(ptr + k) % N_REQ]) win = (ptr + k) % N_REQ;
    end
    if (win >= 0) eg[win] = 1'b1;
    chk("grant", req_ready, eg);
    if (rsp_id.exists(cyc)) begin
      ev = '0;
      ev[rsp_id[cyc]] = 1'b1;
      chk("resp_valid", resp_valid, ev);
      chk("resp_data", resp_data, rsp_dat[cyc]);
      chk("resp_err", resp_err, rsp_er[cyc]);
    end else begin
      chk("resp_quiet", resp_valid, 0);
    end
    if (op_map.exists(cyc)) chk("mem_req", mem_req, op_map[cyc]);
    else chk("mem_idle", {mem_req.we, mem_req.re}, 0);
    chk("busy", busy, busy_map.exists(cyc));
    if (win >= 0) begin
      p        = req_in[win];
      last_win = win;
      ptr      = (win + 1) % N_REQ;
      wr       = p.we;
      rd       = p.re && !p.we;
      key      = mkey(p.bank_sel, p.addr);
      b        = int'(p.bank_sel);
`ifdef MEM_ARB_PWR_CHECK_EN
      ok = (b < BRAM_BANKS) && bank_power_en[b];
`else
      ok = (b >= 0);
`endif
      if (wr && ok) begin
        op = p;
        op.re = 1'b0;
        op_map[cyc+1]   = op;
        refmem[key]     = p.data;
        busy_map[cyc+1] = 1'b1;
      end
      if (rd) begin
        for (int t = cyc + 1; t <= cyc + 1 + RD_LAT; t++) busy_map[t] = 1'b1;
        rsp_id[cyc+1+RD_LAT] = win;
        if (ok) begin
          op_map[cyc+1] = p;
          rsp_dat[cyc+1+RD_LAT] = refmem.exists(key) ? refmem[key] : '0;
          rsp_er[cyc+1+RD_LAT]  = 1'b0;
        end else begin
          rsp_dat[cyc+1+RD_LAT] = '0;
          rsp_er[cyc+1+RD_LAT]  = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue(input int id, input bit we, input bit re, input int bank,
                       input int addr, input logic [DATA_WIDTH-1:0] data, output int acc);
    mem_req_t r;
    r          = '0;
    r.we       = we;
    r.re       = re;
    r.bank_sel = BANK_W'(bank);
    r.addr     = ADDR_WIDTH'(addr);
    r.data     = data;
    req_in[id]    = r;
    req_valid[id] = 1'b1;
    acc = -1;
    for (int t = 0; t < 20 && acc < 0; t++) begin
      cycle();
      if (last_win == id) acc = cyc - 1;
    end
    req_valid[id] = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r.we       = 1'($urandom_range(0, 1));
    r.re       = 1'($urandom_range(0, 1));
    r.bank_sel = ($urandom_range(0, 7) == 0) ? BANK_W'(28) : BANK_W'($urandom_range(0, 5));
    r.addr     = ADDR_WIDTH'($urandom_range(0, 7));
    r.data     = $urandom;
    return r;
  endfunction

  initial begin
    int a;
    int b2;
    rst           = 1'b1;
    req_valid     = '0;
    bank_power_en = '1;
    for (int i = 0; i < N_REQ; i++) req_in[i] = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    issue(0, 1, 0, 0, 'h10, 'hAA, a);
    idle(2);
    chk("wr_we_pulse", obs_we[a+1], 1);
    chk("wr_we_single", obs_we[a+2], 0);
    issue(0, 0, 1, 0, 'h10, 0, a);
    idle(RD_LAT + 2);
    chk("rd_not_early", obs_rv[a+RD_LAT], 0);
    chk("rd_valid", obs_rv[a+1+RD_LAT], 4'b0001);
    chk("rd_data", obs_rd[a+1+RD_LAT], 'hAA);

    issue(3, 1, 0, 4, 'h20, 'hBB, a);
    issue(3, 1, 0, 18, 'h05, 'hCC, a);
    issue(2, 0, 1, 4, 'h20, 0, a);
    issue(1, 0, 1, 18, 'h05, 0, b2);
    idle(RD_LAT + 2);
    chk("route_b2b", b2, a + 1);
    chk("route_r2_valid", obs_rv[a+1+RD_LAT], 4'b0100);
    chk("route_r2_data", obs_rd[a+1+RD_LAT], 'hBB);
    chk("route_r1_valid", obs_rv[a+2+RD_LAT], 4'b0010);
    chk("route_r1_data", obs_rd[a+2+RD_LAT], 'hCC);

`ifdef MEM_ARB_PWR_CHECK_EN
    bank_power_en[4] = 1'b0;
    issue(0, 1, 0, 4, 'h30, 'hDD, a);
    issue(0, 0, 1, 4, 'h30, 0, b2);
    idle(RD_LAT + 2);
    chk("pwr_no_we", obs_we[a+1], 0);
    chk("pwr_err_valid", obs_rv[b2+1+RD_LAT], 4'b0001);
    chk("pwr_err_flag", obs_err[b2+1+RD_LAT], 1);
    chk("pwr_err_data", obs_rd[b2+1+RD_LAT], 0);
    bank_power_en[4] = 1'b1;
    issue(0, 0, 1, 4, 'h20, 0, a);
    idle(RD_LAT + 2);
    chk("repower_valid", obs_rv[a+1+RD_LAT], 4'b0001);
    chk("repower_data", obs_rd[a+1+RD_LAT], 'hBB);
    chk("repower_err", obs_err[a+1+RD_LAT], 0);
`endif

    issue(2, 1, 0, 1, 'h01, 'h55, a);
    issue(3, 0, 1, 4, 'h20, 0, a);
    rst       = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_in[i] = '0;
    #1;
    chk("rst_now_ready", req_ready, 0);
    chk("rst_now_mem_req", mem_req, 0);
    chk("rst_now_busy", busy, 0);
    chk("rst_now_resp", resp_valid, 0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("fair_order", last_win, i % 4);
      chk("post_rst_quiet", obs_rv[cyc-1], 0);
    end
    req_valid = '0;
    idle(1);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && last_win == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_in[i]    = rand_req();
          req_valid[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        int pb;
        pb = $urandom_range(0, BRAM_BANKS - 1);
        bank_power_en[pb] = ~bank_power_en[pb];
      end
      cycle();
    end
    req_valid = '0;
    idle(RD_LAT + 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single `mem_req_t`/`mem_resp_t` port of `memory_controller` among `N_REQ` requesters (input loader, compute engine, output writer, host debug). It accepts one request per cycle with a valid/ready handshake and registers the winning request onto the controller port. It tracks outstanding reads in a tag pipeline so each read response returns only to the requester that issued it. It sits directly between the accelerator engines and `memory_controller`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `RD_LAT`, 2: cycles from `mem_req.re` presented to `mem_resp.valid` from the controller, 1..4.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in [N_REQ]: requester i has a request.
- `req_in` in mem_req_t [N_REQ]: request payload; held stable while `req_valid` is high and `req_ready` is low.
- `req_ready` out [N_REQ]: one-hot grant; the request is accepted on `req_valid & req_ready`.
- `resp_valid` out [N_REQ]: one-hot read-data strobe.
- `resp_data` out DATA_WIDTH: read data, shared by all requesters, qualified by `resp_valid`.
- `resp_err` out 1: read targeted an unpowered or invalid bank; qualified by `resp_valid`.
- `mem_req` out mem_req_t: to `memory_controller`.
- `mem_resp` in mem_resp_t: from `memory_controller`.
- `bank_power_en` in [BRAM_BANKS]: same vector that drives `memory_controller`.
- `busy` out 1: a read is outstanding, or `mem_req` carries an operation.

## Operation
- **Arbitration (combinational):** the search starts at `rr_ptr` and the first requester with `req_valid` high receives `req_ready`. All other `req_ready` bits are 0.
  - On acceptance, `rr_ptr` becomes (winner+1) mod N_REQ.
  - With no valid request, `rr_ptr` holds.
- **Issue (registered):** the accepted payload drives `mem_req` for exactly one cycle. Otherwise `mem_req.we` and `mem_req.re` are 0, and addr/data/bank_sel hold their last value.
- **Opcode rules:**
  - `we` and `re` both 1: treated as a write; `re` is forced to 0.
  - Neither set: the request is accepted and consumed, and no operation is issued.
- **Tag pipeline:** RD_LAT-deep shift register of `{valid, err, id}`.
  - An entry is inserted when the issued operation is a read.
  - At the head, `resp_valid[id]` = `mem_resp.valid`, and `resp_data` = `mem_resp.data`.
  - If `mem_resp.valid` arrives with no valid head tag, it is ignored.
- **Throughput:** one accept per cycle, independent of outstanding reads, because `memory_controller` is pipelined.
- **Reset values:**
  - `req_ready` = `resp_valid` = 0; `mem_req` = 0; `resp_data` = 0; `resp_err` = 0; `busy` = 0.
  - `rr_ptr` = 0; all tags invalid.
- **Reset mid-operation:** outstanding reads are discarded, and no `resp_valid` follows from pre-reset requests.

## Timing
- Request accepted in cycle c → `mem_req` valid in cycle c+1 → `resp_valid` in cycle c+1+RD_LAT.
- Read-to-requester latency is RD_LAT+1 cycles from acceptance.
- **Simultaneous events:** a read response from an earlier request and a new grant to the same requester may occur in the same cycle; both are honoured.
- `busy` is registered and reflects the state after the edge.

## Configuration
- `MEM_ARB_PWR_CHECK_EN` defined:
  - A request whose `bank_sel` is ≥ BRAM_BANKS, or whose `bank_power_en[bank_sel]` is 0 at acceptance, is accepted but not forwarded (`mem_req.we`/`re` stay 0).
  - A blocked read still inserts a tag with `err` = 1. RD_LAT+1 cycles after acceptance it produces `resp_valid` with `resp_err` = 1 and `resp_data` = 0, without waiting for `mem_resp.valid`.
- Undefined:
  - All requests are forwarded unconditionally.
  - `bank_power_en` is ignored and `resp_err` is tied to 0.

## Structure
- `accel_pkg` gains:
  - `arb_tag_t` {valid, err, id[$clog2(MEM_ARB_MAX_REQ)-1:0]}.
  - `MEM_ARB_MAX_REQ` = 8.
- `mem_req_t`, `mem_resp_t`, `BRAM_BANKS` and `DATA_WIDTH` are reused from `accel_pkg`.
- One sub-module, `rr_arbiter`: the N-way round-robin pick plus the `rr_ptr` register, with a `valid` and `accept` interface. It is reusable by other shared resources.

## Test plan
- **Single write/read:** R0 writes bank 0, addr 0x0010, data 0xAA; then R0 reads the same location.
  - `mem_req.we` is 1 for exactly one cycle.
  - `resp_valid[0]` = 1 with `resp_data` = 0xAA at RD_LAT+1 cycles after the read is accepted.
- **Fairness:** all four requesters hold `req_valid` high continuously.
  - Grants go 0,1,2,3,0,… with one accept per cycle.
  - No requester waits more than 3 cycles.
- **Response routing:** back-to-back reads from R2 (bank 4, 0x0020 = 0xBB) then R1 (bank 18, 0x0005 = 0xCC), with RD_LAT = 2.
  - `resp_valid[2]` with 0xBB, followed in the next cycle by `resp_valid[1]` with 0xCC.
- **Power check (macro on):** `bank_power_en[4]` = 0, R0 writes bank 4, 0x0030 = 0xDD, then reads.
  - No `mem_req.we` is issued.
  - The read returns `resp_err` = 1 with data 0.
  - After re-powering bank 4, reading 0x0020 returns 0xBB.
- **Reset mid-read:** assert `rst` 1 cycle after a read is accepted.
  - All outputs are 0 immediately.
  - No `resp_valid` for 10 cycles.
  - `rr_ptr` restarts at R0.
